// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory loader.
//   loader_state_e  : loader FSM states
//   WORD_W          : memory word width in bits
//   BYTES_PER_WORD  : stream bytes per memory word
package loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream into the loader and word writes out of it.
//   in_valid/in_data/in_ready : byte stream; a byte transfers on a posedge
//                               where in_valid && in_ready. in_valid may
//                               rise or fall at any time; in_ready does not
//                               depend on in_valid.
//   mem_we/mem_addr/mem_wdata : instruction memory write port, no backpressure
//   master : image source / memory side
//   slave  : the loader
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  import loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles accepted stream bytes into big-endian 32-bit words.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : restart packing from byte 0 (loader state entry)
//   byte_valid  : a byte is accepted this cycle
//   byte_data   : the accepted byte
//   word_valid  : one-cycle flag, the 4th byte of a word is accepted now
//   word_data   : {b0,b1,b2,b3}, valid with word_valid
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [1:0]  cnt_q, cnt_d;
  // Only the first three bytes need storing; the fourth is taken live.
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;  // wraps 3 -> 0
      shift_d = {shift_q[15:0], byte_data};
    end
  end

  assign word_valid = byte_valid && !clear && (cnt_q == 2'd3);
  assign word_data  = {shift_q, byte_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image (length N, N data words,
// XOR checksum) over a byte stream, writes the data words to instruction
// memory from address 0, and holds the processor until the image checks out.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a load (honoured in IDLE, DONE, ERROR only)
//   lif        : byte stream in, memory write port out (slave modport)
//   cpu_hold   : 1 except in DONE
//   done       : image loaded, checksum matched
//   error      : length overflow or checksum mismatch
//   dbg_state  : current FSM state
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  lif,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output loader_state_e dbg_state
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;  // one extra bit so N = DEPTH fits
  logic [ADDR_W:0]   len_q, len_d;
  logic [WORD_W-1:0] xor_q, xor_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              in_ready;
  logic              restart;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;

  assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign restart  = start &&
                    ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .byte_valid (lif.in_valid && in_ready),
    .byte_data  (lif.in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    xor_d       = xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (restart) begin
          state_d    = LEN;
          word_cnt_d = '0;
          len_d      = '0;
          xor_d      = '0;
          mem_addr_d = '0;
        end
      end
      LEN: begin
        if (word_valid) begin
          if (word_data == '0) begin
            state_d = CSUM;
          end else if (word_data > 32'(DEPTH)) begin
            state_d = ERROR;
          end else begin
            len_d   = word_data[ADDR_W:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          // mem_addr shows the address of the write in progress, taken from
          // the word count before it advances, so it never exceeds DEPTH-1.
          mem_we_d    = 1'b1;
          mem_addr_d  = word_cnt_q[ADDR_W-1:0];
          mem_wdata_d = word_data;
          xor_d       = xor_q ^ word_data;
          word_cnt_d  = word_cnt_q + (ADDR_W+1)'(1);
          if (word_cnt_d == len_q) state_d = CSUM;
        end
      end
      CSUM: begin
        if (word_valid) state_d = (word_data == xor_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      len_q       <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      xor_q       <= xor_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign lif.in_ready  = in_ready;
  assign lif.mem_we    = mem_we_q;
  assign lif.mem_addr  = mem_addr_q;
  assign lif.mem_wdata = mem_wdata_q;
  assign cpu_hold      = (state_q != DONE);
  assign done          = (state_q == DONE);
  assign error         = (state_q == ERROR);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed images into imem_loader and checks every
// memory write against an expected queue, plus status outputs per frame.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cpu_hold, done, error;
  loader_state_e dbg_state;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) lif ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lif       (lif.slave),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [ADDR_W+31:0] exp_q[$];   // {addr, data} per expected write
  logic [31:0]        img[$];     // data words of the frame being sent
  bit                 gappy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (lif.mem_we) begin
      logic [ADDR_W+31:0] e;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(lif.mem_addr), 64'(e[ADDR_W+31:32]));
        check("wr_data", 64'(lif.mem_wdata), 64'(e[31:0]));
      end
    end
  end

  function automatic logic [31:0] xor_img();
    logic [31:0] x = '0;
    foreach (img[i]) x ^= img[i];
    return x;
  endfunction

  // ---------------- drivers (called at posedge + #1) ----------------
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    lif.in_valid = 1'b1;
    lif.in_data  = b;
    while (!lif.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!lif.in_ready) begin
      check("in_ready_wait", 64'(lif.in_ready), 64'd1);
      lif.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lif.in_valid = 1'b0;
    if (gappy) begin
      repeat ($urandom_range(0, 2)) begin
        lif.in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("in_ready_after_start", 64'(lif.in_ready), 64'd1);
  endtask

  // Sends the frame held in img; optionally pulses start after data word k.
  task automatic run_frame(input logic [31:0] csum, input bit exp_ok, input int pulse_after);
    start_load();
    send_word(32'(img.size()));
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({ADDR_W'(i), img[i]});
      send_word(img[i]);
      if (i == pulse_after) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_ignored_state", 64'(dbg_state), 64'(DATA));
      end
    end
    send_word(csum);
    check("done", 64'(done), 64'(exp_ok));
    check("error", 64'(error), 64'(!exp_ok));
    check("cpu_hold", 64'(cpu_hold), 64'(!exp_ok));
    check("in_ready_end", 64'(lif.in_ready), 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_prog3();
    img.delete();
    img.push_back(32'h20010005);
    img.push_back(32'h20020007);
    img.push_back(32'h00221820);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lif.in_valid = 1'b0;
    lif.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(lif.in_ready), 64'd0);
    check("rst_mem_we", 64'(lif.mem_we), 64'd0);
    check("rst_mem_addr", 64'(lif.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(lif.mem_wdata), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-word program; XOR of the words is 0x00211822.
    load_prog3();
    check("model_xor3", 64'(xor_img()), 64'h00211822);
    run_frame(xor_img(), 1'b1, -1);
    // Same image, wrong checksum: writes still happen, then error.
    run_frame(32'h00000000, 1'b0, -1);
    run_frame(32'h00231822, 1'b0, -1);

    // Length overflow: DEPTH+1.
    start_load();
    send_word(32'h00000401);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_done", 64'(done), 64'd0);
    check("ovf_in_ready", 64'(lif.in_ready), 64'd0);
    check("ovf_cpu_hold", 64'(cpu_hold), 64'd1);
    repeat (4) begin @(posedge clk); #1; end

    // Empty image, then a single word.
    img.delete();
    run_frame(32'h00000000, 1'b1, -1);
    img.push_back(32'hDEADBEEF);
    run_frame(32'hDEADBEEF, 1'b1, -1);

    // Gapped stream with a start pulse in the middle of DATA.
    gappy = 1'b1;
    load_prog3();
    run_frame(xor_img(), 1'b1, 0);
    gappy = 1'b0;

    // Reset after the second data word, then a clean reload.
    start_load();
    send_word(32'd3);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({ADDR_W'(i), img[i]});
      send_word(img[i]);
    end
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_drained", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    check("midrst_in_ready", 64'(lif.in_ready), 64'd0);
    check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("midrst_mem_addr", 64'(lif.mem_addr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(xor_img(), 1'b1, -1);

    // Full-depth image: last address DEPTH-1.
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    run_frame(xor_img(), 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
